// File: rtl/decode_stage_if.sv
// IF/ID to ID handshake: instruction bus from fetch, acceptance back from decode.
interface decode_stage_if;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;

    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               id_ready;

    // Fetch side drives the instruction and observes acceptance.
    modport master (
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready
    );

    // Decode side consumes the instruction and reports acceptance.
    modport slave (
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready
    );
endinterface

// File: rtl/decode_stage.sv
// ID stage: register-file addressing, instruction decode, load-use bubble
// insertion and the ID/EX pipeline register.
module decode_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    decode_stage_if.slave     fetch,
    input  logic              flush,
    input  logic              ex_hold,
    output logic [AW-1:0]     rf_raddr1,
    output logic [AW-1:0]     rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              ex_valid,
    output logic [15:0]       ex_pc,
    output logic [2:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_src_a,
    output logic [DATA_W-1:0] ex_src_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [AW-1:0]     ex_rd,
    output logic [AW-1:0]     ex_rs1,
    output logic [AW-1:0]     ex_rs2,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_illegal,
    output logic [15:0]       stall_count
);
    localparam int unsigned OP_W    = 5;
    localparam int unsigned IMM_W   = 5;
    localparam int unsigned STALL_W = 16;

    localparam logic [OP_W-1:0] OP_NOP     = 5'b00000;
    localparam logic [OP_W-1:0] OP_RR_LAST = 5'b00111;
    localparam logic [OP_W-1:0] OP_RI_LAST = 5'b01111;
    localparam logic [OP_W-1:0] OP_LDD     = 5'b10000;
    localparam logic [OP_W-1:0] OP_STD     = 5'b10001;

    logic [OP_W-1:0]   op;
    logic [2:0]        f_rd;
    logic [2:0]        f_rs1;
    logic [2:0]        f_rs2;
    logic [IMM_W-1:0]  f_imm;
    logic [DATA_W-1:0] imm_sext;

    logic reads1;
    logic reads2;
    logic use_imm;
    logic is_store;
    logic d_reg_write;
    logic d_mem_read;
    logic d_mem_write;
    logic d_illegal;
    logic hz;

    assign op       = fetch.if_instr[15:11];
    assign f_rd     = fetch.if_instr[10:8];
    assign f_rs1    = fetch.if_instr[7:5];
    assign f_rs2    = fetch.if_instr[4:2];
    assign f_imm    = fetch.if_instr[4:0];
    assign imm_sext = {{(DATA_W-IMM_W){f_imm[IMM_W-1]}}, f_imm};

    // Opcode class decode: which ports are read and which control bits fire.
    always_comb begin
        reads1      = 1'b0;
        reads2      = 1'b0;
        use_imm     = 1'b0;
        is_store    = 1'b0;
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_illegal   = 1'b0;
        if (op == OP_NOP) begin
            d_illegal = 1'b0;
        end else if (op <= OP_RR_LAST) begin
            reads1      = 1'b1;
            reads2      = 1'b1;
            d_reg_write = 1'b1;
        end else if (op <= OP_RI_LAST) begin
            reads1      = 1'b1;
            use_imm     = 1'b1;
            d_reg_write = 1'b1;
        end else if (op == OP_LDD) begin
            reads1      = 1'b1;
            use_imm     = 1'b1;
            d_reg_write = 1'b1;
            d_mem_read  = 1'b1;
        end else if (op == OP_STD) begin
            reads1      = 1'b1;
            reads2      = 1'b1;
            use_imm     = 1'b1;
            is_store    = 1'b1;
            d_mem_write = 1'b1;
        end else begin
            d_illegal = 1'b1;
        end
    end

    // Register-file addresses; STD routes rd through port 2 as store data.
    assign rf_raddr1 = AW'(f_rs1);
    assign rf_raddr2 = is_store ? AW'(f_rd) : AW'(f_rs2);

    // Load-use hazard: the load in EX targets a register this instruction reads.
    assign hz = ex_valid & ex_mem_read & fetch.if_valid &
                ((reads1 & (ex_rd == rf_raddr1)) | (reads2 & (ex_rd == rf_raddr2)));

    // Acceptance: flush always drops the instruction; otherwise hold or hazard stall it.
    assign fetch.id_ready = ~rst & (flush | (~ex_hold & ~hz));

    // ID/EX register and bubble counter with rst > flush > hold > hazard > normal.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_alu_op     <= '0;
            ex_src_a      <= '0;
            ex_src_b      <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_illegal    <= 1'b0;
            stall_count   <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (ex_hold) begin
            ex_valid <= ex_valid;
        end else if (hz) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_illegal   <= 1'b0;
            if (stall_count != {STALL_W{1'b1}}) begin
                stall_count <= stall_count + STALL_W'(1);
            end
        end else if (fetch.if_valid) begin
            ex_valid      <= 1'b1;
            ex_pc         <= fetch.if_pc;
            ex_alu_op     <= op[2:0];
            ex_src_a      <= rf_rdata1;
            ex_src_b      <= use_imm ? imm_sext : rf_rdata2;
            ex_store_data <= is_store ? rf_rdata2 : '0;
            ex_rd         <= AW'(f_rd);
            ex_rs1        <= rf_raddr1;
            // Forwarding wants the index actually read on port 2 (rd for STD).
            ex_rs2        <= rf_raddr2;
            ex_reg_write  <= d_reg_write;
            ex_mem_read   <= d_mem_read;
            ex_mem_write  <= d_mem_write;
            ex_illegal    <= d_illegal;
        end else begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end
    end
endmodule
